// File: rtl/prf_rf_pkg.sv
// Shared physical-register-file constants and port-packing helpers.
// NCPU_PRF_AW may be supplied by the build; otherwise a 32-entry file is assumed.
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 5
`endif

package prf_rf_pkg;

    localparam int PRF_AW = `NCPU_PRF_AW;
    localparam int PRF_N  = 1 << PRF_AW;

    // Read ports: two operands (rs1, rs2) per issue lane.
    function automatic int rp_count(input int p_issue_width);
        return 2 * (1 << p_issue_width);
    endfunction

    function automatic int wp_count(input int p_write_width);
        return 1 << p_write_width;
    endfunction

    // LSB of a port's field inside a packed multi-port bus.
    function automatic int pack_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/prf_rf_rport.sv
// One read port: address mux, optional same-edge write bypass, and the RDATA hold register.
// Bypass is compiled in when PRF_BYPASS_EN is defined.
module prf_rf_rport
    import prf_rf_pkg::*;
#(
    parameter int DW = 64,
    parameter int WP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic [PRF_AW-1:0] raddr,
    input  logic [DW-1:0]     mem [PRF_N],
    input  logic [WP-1:0]     we,
    input  logic [WP*PRF_AW-1:0] waddr,
    input  logic [WP*DW-1:0]  wdata,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] rd_val;

`ifdef PRF_BYPASS_EN
    always_comb begin
        rd_val = mem[raddr];
        // Ascending scan so the highest matching write port wins, matching storage priority.
        for (int w = 0; w < WP; w++) begin
            if (we[w] && (waddr[pack_lsb(w, PRF_AW) +: PRF_AW] == raddr)) begin
                rd_val = wdata[pack_lsb(w, DW) +: DW];
            end
        end
        if (raddr == '0) begin
            rd_val = '0;
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{we, waddr, wdata};

    always_comb begin
        rd_val = mem[raddr];
        if (raddr == '0) begin
            rd_val = '0;
        end
    end
`endif

    // Held while re is low so the operand stage can stall without re-reading.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_val;
        end
    end

endmodule

// File: rtl/prf_rf.sv
// Physical register file: N x CONFIG_DW storage, WP write ports, RP registered read ports.
// Define PRF_BYPASS_EN to forward same-edge write data to reads of the same address.
module prf_rf
    import prf_rf_pkg::*;
#(
    parameter int CONFIG_P_ISSUE_WIDTH = 0,
    parameter int CONFIG_P_WRITE_WIDTH = 0,
    parameter int CONFIG_DW            = 64,
    localparam int RP = rp_count(CONFIG_P_ISSUE_WIDTH),
    localparam int WP = wp_count(CONFIG_P_WRITE_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RP-1:0]            prf_RE,
    input  logic [RP*PRF_AW-1:0]     prf_RADDR,
    output logic [RP*CONFIG_DW-1:0]  prf_RDATA,
    input  logic [WP-1:0]            prf_WE,
    input  logic [WP*PRF_AW-1:0]     prf_WADDR,
    input  logic [WP*CONFIG_DW-1:0]  prf_WDATA
);

    logic [CONFIG_DW-1:0] mem [PRF_N];

    // Later loop iterations override earlier ones, so the highest-indexed port wins a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PRF_N; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int w = 0; w < WP; w++) begin
                if (prf_WE[w] && (prf_WADDR[pack_lsb(w, PRF_AW) +: PRF_AW] != '0)) begin
                    mem[prf_WADDR[pack_lsb(w, PRF_AW) +: PRF_AW]]
                        <= prf_WDATA[pack_lsb(w, CONFIG_DW) +: CONFIG_DW];
                end
            end
        end
    end

    for (genvar r = 0; r < RP; r++) begin : g_rport
        prf_rf_rport #(
            .DW (CONFIG_DW),
            .WP (WP)
        ) u_rport (
            .clk   (clk),
            .rst   (rst),
            .re    (prf_RE[r]),
            .raddr (prf_RADDR[r*PRF_AW +: PRF_AW]),
            .mem   (mem),
            .we    (prf_WE),
            .waddr (prf_WADDR),
            .wdata (prf_WDATA),
            .rdata (prf_RDATA[r*CONFIG_DW +: CONFIG_DW])
        );
    end

endmodule

// File: tb/tb_prf_rf.sv
// Directed bench for prf_rf with two write ports; expectations follow PRF_BYPASS_EN when defined.
module tb_prf_rf;
    import prf_rf_pkg::*;

    localparam int DW = 64;
    localparam int RP = 2;
    localparam int WP = 2;
    localparam int AW = PRF_AW;
    localparam int N  = PRF_N;

`ifdef PRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [RP-1:0]     re;
    logic [RP*AW-1:0]  raddr;
    logic [RP*DW-1:0]  rdata;
    logic [WP-1:0]     we;
    logic [WP*AW-1:0]  waddr;
    logic [WP*DW-1:0]  wdata;

    int n_checks = 0;
    int n_fail   = 0;

    prf_rf #(
        .CONFIG_P_ISSUE_WIDTH (0),
        .CONFIG_P_WRITE_WIDTH (1),
        .CONFIG_DW            (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .prf_RE    (re),
        .prf_RADDR (raddr),
        .prf_RDATA (rdata),
        .prf_WE    (we),
        .prf_WADDR (waddr),
        .prf_WDATA (wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return rdata[p*DW +: DW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        re = '0;
        we = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        re[p] = 1'b1;
        raddr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[p] = 1'b1;
        waddr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] ra [3];
        ra[0] = '0;
        ra[1] = AW'(1);
        ra[2] = AW'(N - 1);

        rst = 1'b0;
        idle();
        raddr = '0;
        waddr = '0;
        wdata = '0;
        step();
        step();
        check("reset_rdata0", rd(0), '0);
        check("reset_rdata1", rd(1), '0);
        rst = 1'b1;

        // Storage cleared: reads of 0, 1 and N-1 on both ports
        for (int i = 0; i < 3; i++) begin
            idle();
            set_rd(0, ra[i]);
            set_rd(1, ra[i]);
            step();
            check($sformatf("reset_read_p0_a%0d", ra[i]), rd(0), '0);
            check($sformatf("reset_read_p1_a%0d", ra[i]), rd(1), '0);
        end

        // Write then read
        idle();
        set_wr(0, AW'(5), 64'hDEADBEEF);
        step();
        idle();
        set_rd(0, AW'(5));
        set_rd(1, AW'(5));
        step();
        check("wr_rd_p0", rd(0), 64'hDEADBEEF);
        check("wr_rd_p1", rd(1), 64'hDEADBEEF);

        // Same-edge hazard on addr 7
        idle();
        set_wr(1, AW'(7), 64'h11);
        step();
        idle();
        set_wr(0, AW'(7), 64'h22);
        set_rd(0, AW'(7));
        set_rd(1, AW'(7));
        step();
        check("hazard_p0", rd(0), BYP ? 64'h22 : 64'h11);
        check("hazard_p1", rd(1), BYP ? 64'h22 : 64'h11);
        idle();
        set_rd(0, AW'(7));
        step();
        check("hazard_after", rd(0), 64'h22);

        // Write priority on addr 3 (previously 0)
        idle();
        set_wr(0, AW'(3), 64'hAA);
        set_wr(1, AW'(3), 64'hBB);
        set_rd(0, AW'(3));
        step();
        check("prio_same_edge", rd(0), BYP ? 64'hBB : 64'h0);
        idle();
        set_rd(0, AW'(3));
        set_rd(1, AW'(3));
        step();
        check("prio_after_p0", rd(0), 64'hBB);
        check("prio_after_p1", rd(1), 64'hBB);

        // Zero register, including same-edge write to it
        idle();
        set_wr(0, AW'(0), 64'h55);
        set_wr(1, AW'(0), 64'h66);
        set_rd(0, AW'(0));
        set_rd(1, AW'(0));
        step();
        check("zero_same_edge_p0", rd(0), '0);
        check("zero_same_edge_p1", rd(1), '0);
        idle();
        set_rd(0, AW'(0));
        set_rd(1, AW'(0));
        step();
        check("zero_after_p0", rd(0), '0);
        check("zero_after_p1", rd(1), '0);

        // Hold while stalled, then fresh read
        idle();
        set_wr(0, AW'(4), 64'h44);
        step();
        idle();
        set_rd(0, AW'(4));
        step();
        check("hold_first", rd(0), 64'h44);
        idle();
        set_wr(0, AW'(4), 64'h99);
        step();
        check("hold_c1", rd(0), 64'h44);
        idle();
        step();
        check("hold_c2", rd(0), 64'h44);
        step();
        check("hold_c3", rd(0), 64'h44);
        set_rd(0, AW'(4));
        set_rd(1, AW'(5));
        step();
        check("hold_reread", rd(0), 64'h99);
        check("indep_p1", rd(1), 64'hDEADBEEF);

        // Reset mid-operation: requests ignored, held data discarded
        idle();
        rst = 1'b0;
        set_rd(0, AW'(4));
        set_rd(1, AW'(5));
        set_wr(0, AW'(9), 64'h1234);
        step();
        check("midrst_p0", rd(0), '0);
        check("midrst_p1", rd(1), '0);
        rst = 1'b1;
        idle();
        step();
        check("midrst_hold_p0", rd(0), '0);
        set_rd(0, AW'(4));
        set_rd(1, AW'(9));
        step();
        check("midrst_mem4", rd(0), '0);
        check("midrst_mem9", rd(1), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
